dmem_access_arbiter: RTL
========================

# dmem_access_arbiter

Sequencing controller and two-port arbiter in front of the byte-wide data memory. It accepts 64-bit doubleword load/store requests from two requesters: port 0 is the core load/store path and port 1 is the loader/debug path. It grants one requester at a time and serialises each doubleword into eight little-endian byte beats on the memory port. The block sits between the execute-stage memory signals and the data memory array, and is the only agent that drives memory write-enable.

## Interface
- ADDR_W, 64, requester address width (byte address)
- MEM_AW, 8, memory-side byte address width; beat addresses wrap modulo 2^MEM_AW
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request from port 0 / port 1
- we0 / we1  in  1  1 = store doubleword, 0 = load doubleword
- addr0 / addr1  in  ADDR_W  base byte address
- wdata0 / wdata1  in  64  store data, byte 0 = [7:0]
- rdata0 / rdata1  out  64  load result for that port; held until that port's next load completes
- done0 / done1  out  1  one-cycle completion pulse for that port
- mem_addr  out  MEM_AW  byte address to memory
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  combinational byte read data at mem_addr
- busy  out  1  high whenever state is not IDLE
- grant  out  1  port owning the current transaction; valid while busy

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any req is high, the arbiter picks a winner.
  - The winner's we, addr[MEM_AW-1:0] and wdata are latched, grant is set, the beat counter is cleared, and the FSM moves to XFER.
  - Otherwise the FSM stays in IDLE.
- XFER, beat b = 0..7:
  - mem_addr = latched base + b, modulo 2^MEM_AW.
  - mem_we = latched we.
  - mem_wdata = latched wdata[8b+7:8b].
  - On a load, mem_rdata is captured into staging byte b.
  - At b = 7 the FSM moves to DONE.
- DONE:
  - done<grant> pulses for one cycle.
  - On a load, rdata<grant> is updated from staging in the same cycle.
  - rdata of the other port is untouched, and a store never changes either rdata.
  - The FSM moves to IDLE.
- Outside XFER: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Requesters hold req, we, addr and wdata stable until their done. Changes after the grant are ignored. Dropping req mid-transaction does not abort it; done still pulses.
- A request still high in the cycle after its done is treated as a new transaction.
- Arbitration is evaluated only in IDLE. A request arriving during busy waits.
- Reset mid-transaction:
  - The transaction is abandoned and no done is issued.
  - Bytes already written stay written.
  - All outputs return to reset values on the next edge.
- Reset values:
  - state IDLE; busy 0; grant 0.
  - done0/1 = 0; rdata0/1 = 0.
  - mem_addr 0, mem_we 0, mem_wdata 0.
  - round-robin pointer = "last granted port 1".

## Timing
- Request sampled in IDLE at edge N. Beats are driven during cycles N+1..N+8. done is high in cycle N+9. IDLE is re-entered at N+10.
- Throughput: one doubleword per 10 cycles. A pending request is granted at the N+10 edge.
- rdata is valid from the cycle done is high.
- Memory byte writes take effect at the edge ending each write beat.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous req0 and req1, the port not granted last wins.
  - The pointer updates on every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. The pointer logic is absent.
- In both modes a lone requester is granted immediately.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, XFER, DONE);
  - BEATS = 8;
  - the beat counter width, 3;
  - the port index constants, PORT_CORE = 0 and PORT_LOAD = 1.
- Sub-module dmem_rr_arbiter holds the 2-way grant logic and the pointer, and contains the DMEM_ARB_RR_EN switch.
- Datapath and FSM stay in the top level.

## Test plan
- Port 0 store, addr 0x10, wdata 0x8877665544332211:
  - mem_we is high for 8 cycles at addresses 0x10..0x17 with bytes 0x11..0x88;
  - done0 pulses at N+9.
- Port 0 load from 0x10 after the store above → rdata0 = 0x8877665544332211 with done0; rdata1 stays 0.
- Port 1 store, addr 0xFC, wdata 0x0807060504030201 (MEM_AW = 8) → bytes land at 0xFC..0xFF, then 0x00..0x03 (wrap).
- req0 and req1 both held high continuously:
  - with DMEM_ARB_RR_EN, grants alternate 0, 1, 0, 1;
  - without it, port 0 is granted every time and port 1 is never done.
- reset asserted during beat 4 of a port 1 store:
  - no done1;
  - mem_we = 0 and busy = 0 next cycle;
  - bytes 0..3 are written, 4..7 unchanged.
- req1 raised during a port 0 transaction → port 1 is granted exactly at the edge after done0's cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory access arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BEATS  = 8;
  localparam int BEAT_W = 3;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// rtl/dmem_rr_arbiter.sv - two-way grant selection; DMEM_ARB_RR_EN selects round-robin, else fixed priority
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any_req,
  output logic winner
);

  assign any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Pointer starts as "port 1 granted last" so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_LOAD;
    end else if (take) begin
      last_q <= winner;
    end
  end

  always_comb begin
    winner = PORT_CORE;
    if (req0 && req1) begin
      winner = ~last_q;
    end else if (req1) begin
      winner = PORT_LOAD;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = &{1'b0, clk, reset, take};

  always_comb begin
    winner = PORT_CORE;
    if (!req0 && req1) begin
      winner = PORT_LOAD;
    end
  end
`endif

endmodule

// File: rtl/dmem_access_arbiter.sv
// rtl/dmem_access_arbiter.sv - two-port doubleword arbiter serialising to byte-wide memory (option: DMEM_ARB_RR_EN)
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [63:0]       wdata0,
  input  logic [63:0]       wdata1,
  output logic [63:0]       rdata0,
  output logic [63:0]       rdata1,
  output logic              done0,
  output logic              done1,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              grant
);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic              we_q;
  logic [MEM_AW-1:0] base_q;
  logic [63:0]       wdata_q;
  logic [63:0]       stage_q;
  logic              any_req;
  logic              winner;
  logic              take;
  logic              last_beat;
  logic              in_xfer;
  logic [5:0]        lane;

  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr0[ADDR_W-1:MEM_AW], addr1[ADDR_W-1:MEM_AW]};

  assign take      = (state_q == IDLE) && any_req;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign in_xfer   = (state_q == XFER);
  assign lane      = {beat_q, 3'b000};

  dmem_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .take    (take),
    .any_req (any_req),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = XFER;
      XFER:    if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant   <= PORT_CORE;
      beat_q  <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      stage_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant   <= winner;
            beat_q  <= '0;
            we_q    <= winner ? we1 : we0;
            base_q  <= winner ? addr1[MEM_AW-1:0] : addr0[MEM_AW-1:0];
            wdata_q <= winner ? wdata1 : wdata0;
          end
        end
        XFER: begin
          beat_q <= beat_q + 1'b1;
          if (!we_q) begin
            stage_q[lane +: 8] <= mem_rdata;
            // The final byte bypasses staging so rdata is already valid in the DONE cycle.
            if (last_beat) begin
              if (grant == PORT_LOAD) begin
                rdata1 <= {mem_rdata, stage_q[55:0]};
              end else begin
                rdata0 <= {mem_rdata, stage_q[55:0]};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign done0 = (state_q == DONE) && (grant == PORT_CORE);
  assign done1 = (state_q == DONE) && (grant == PORT_LOAD);

  // Write strobe is masked by reset so an interrupted beat never reaches memory.
  assign mem_we    = in_xfer && we_q && !reset;
  assign mem_addr  = in_xfer ? base_q + MEM_AW'(beat_q) : '0;
  assign mem_wdata = in_xfer ? wdata_q[lane +: 8] : 8'h00;

endmodule
